// File: rtl/esfa_cell_sequencer.sv
// Command sequencer for a broadcast-bus ESFA cell array: issues raw selector ops and a composite INSERT.
// Optional build macro ESFA_SEQ_MULTIHIT_EN flags multi-hit lookups on ops 1, 2, 6 and 7 as errors.
module esfa_cell_sequencer #(
  parameter int N_CELLS = 8,
  parameter int DW      = 8,
  localparam int CW     = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [DW-1:0]         cmd_index,
  input  logic [DW-1:0]         cmd_value,
  input  logic [DW-1:0]         cmd_metadata,
  input  logic                  cmd_is_meta,
  output logic [DW-1:0]         cell_selector,
  output logic [DW-1:0]         cell_index,
  output logic [DW-1:0]         cell_value,
  output logic [DW-1:0]         cell_metadata,
  output logic                  cell_is_meta,
  input  logic [N_CELLS-1:0]    cell_bool,
  input  logic [N_CELLS*DW-1:0] cell_result,
  input  logic [N_CELLS*DW-1:0] cell_context,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_hit,
  output logic [CW-1:0]         resp_cell,
  output logic [DW-1:0]         resp_value,
  output logic [DW-1:0]         resp_context,
  output logic [CW:0]           resp_count,
  output logic                  resp_err
);

  localparam logic [3:0] OP_UPDATE = 4'd0;
  localparam logic [3:0] OP_MARK   = 4'd5;
  localparam logic [3:0] OP_INSERT = 4'd8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE       = 3'd1,
    SAMPLE      = 3'd2,
    ISSUE_SCAN  = 3'd3,
    SAMPLE_SCAN = 3'd4,
    ISSUE_WR    = 3'd5,
    SAMPLE_WR   = 3'd6,
    RESP        = 3'd7
  } state_t;

  function automatic logic [DW-1:0] ext_op(input logic [3:0] op);
    logic [DW-1:0] r;
    r      = '0;
    r[3:0] = op;
    return r;
  endfunction

  function automatic logic [DW-1:0] ext_cell(input logic [CW-1:0] c);
    logic [DW-1:0] r;
    r         = '0;
    r[CW-1:0] = c;
    return r;
  endfunction

  function automatic logic [CW-1:0] lowest_set(input logic [N_CELLS-1:0] m);
    logic [CW-1:0] r;
    r = '0;
    for (int i = N_CELLS - 1; i >= 0; i--) begin
      if (m[i]) begin
        r = CW'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [CW:0] pop_count(input logic [N_CELLS-1:0] m);
    logic [CW:0] r;
    r = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      r = r + {{CW{1'b0}}, m[i]};
    end
    return r;
  endfunction

  state_t        state_r, next_state_s;
  logic [3:0]    op_r;
  logic [DW-1:0] index_r, value_r;
  logic [CW-1:0] free_r;

  logic          accept_s, any_bool_s, bool_free_s, multi_err_s;
  logic [CW-1:0] low_s;
  logic [CW:0]   cnt_s;
  logic [DW-1:0] res_low_s, ctx_low_s, res_free_s, ctx_free_s;

  logic          next_ready_s, next_is_meta_s;
  logic [DW-1:0] next_sel_s, next_idx_s, next_val_s, next_meta_s;
  logic          next_rvalid_s, next_hit_s, next_err_s;
  logic [CW-1:0] next_cell_s;
  logic [DW-1:0] next_rvalue_s, next_rctx_s;
  logic [CW:0]   next_count_s;

  assign accept_s    = cmd_valid && cmd_ready;
  assign any_bool_s  = |cell_bool;
  assign low_s       = lowest_set(cell_bool);
  assign cnt_s       = pop_count(cell_bool);
  assign res_low_s   = cell_result[int'(low_s) * DW +: DW];
  assign ctx_low_s   = cell_context[int'(low_s) * DW +: DW];
  assign res_free_s  = cell_result[int'(free_r) * DW +: DW];
  assign ctx_free_s  = cell_context[int'(free_r) * DW +: DW];
  assign bool_free_s = cell_bool[free_r];

`ifdef ESFA_SEQ_MULTIHIT_EN
  assign multi_err_s = ((op_r == 4'd1) || (op_r == 4'd2) || (op_r == 4'd6) || (op_r == 4'd7))
                       && (cnt_s > (CW+1)'(1));
`else
  assign multi_err_s = 1'b0;
`endif

  // State, bus and response registers; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cmd_ready     <= 1'b1;
      cell_selector <= ext_op(OP_MARK);
      cell_index    <= '0;
      cell_value    <= '0;
      cell_metadata <= '0;
      cell_is_meta  <= 1'b0;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_cell     <= '0;
      resp_value    <= '0;
      resp_context  <= '0;
      resp_count    <= '0;
      resp_err      <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      cmd_ready     <= next_ready_s;
      cell_selector <= next_sel_s;
      cell_index    <= next_idx_s;
      cell_value    <= next_val_s;
      cell_metadata <= next_meta_s;
      cell_is_meta  <= next_is_meta_s;
      resp_valid    <= next_rvalid_s;
      resp_hit      <= next_hit_s;
      resp_cell     <= next_cell_s;
      resp_value    <= next_rvalue_s;
      resp_context  <= next_rctx_s;
      resp_count    <= next_count_s;
      resp_err      <= next_err_s;
    end
  end

  // Command field latches and the free cell found by the INSERT scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= 4'd0;
      index_r <= '0;
      value_r <= '0;
      free_r  <= '0;
    end else begin
      if (accept_s) begin
        op_r    <= cmd_op;
        index_r <= cmd_index;
        value_r <= cmd_value;
      end else begin
        op_r    <= op_r;
        index_r <= index_r;
        value_r <= value_r;
      end
      if (state_r == SAMPLE_SCAN) begin
        free_r <= low_s;
      end else begin
        free_r <= free_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s)               next_state_s = IDLE;
        else if (cmd_op == OP_INSERT) next_state_s = ISSUE_SCAN;
        else if (cmd_op > OP_INSERT)  next_state_s = RESP;
        else                          next_state_s = ISSUE;
      end
      ISSUE:       next_state_s = SAMPLE;
      SAMPLE:      next_state_s = RESP;
      ISSUE_SCAN:  next_state_s = SAMPLE_SCAN;
      SAMPLE_SCAN: next_state_s = any_bool_s ? ISSUE_WR : RESP;
      ISSUE_WR:    next_state_s = SAMPLE_WR;
      SAMPLE_WR:   next_state_s = RESP;
      RESP:        next_state_s = resp_ready ? IDLE : RESP;
      default:     next_state_s = IDLE;
    endcase
  end

  // Output values for the next cycle: bus follows the state being entered, response is captured on entry to RESP.
  always_comb begin
    next_ready_s   = (next_state_s == IDLE);
    next_sel_s     = ext_op(OP_MARK);
    next_idx_s     = '0;
    next_val_s     = '0;
    next_meta_s    = '0;
    next_is_meta_s = 1'b0;
    case (next_state_s)
      ISSUE: begin
        next_sel_s     = ext_op(cmd_op);
        next_idx_s     = cmd_index;
        next_val_s     = cmd_value;
        next_meta_s    = cmd_metadata;
        next_is_meta_s = cmd_is_meta;
      end
      ISSUE_WR: begin
        next_sel_s     = ext_op(OP_UPDATE);
        next_idx_s     = index_r;
        next_val_s     = value_r;
        next_meta_s    = ext_cell(low_s);
        next_is_meta_s = 1'b1;
      end
      default: next_sel_s = ext_op(OP_MARK);
    endcase

    next_rvalid_s = resp_valid;
    next_hit_s    = resp_hit;
    next_cell_s   = resp_cell;
    next_rvalue_s = resp_value;
    next_rctx_s   = resp_context;
    next_count_s  = resp_count;
    next_err_s    = resp_err;
    case (state_r)
      IDLE: begin
        if (accept_s && (cmd_op > OP_INSERT)) begin
          next_rvalid_s = 1'b1;
          next_hit_s    = 1'b0;
          next_cell_s   = '0;
          next_rvalue_s = '0;
          next_rctx_s   = '0;
          next_count_s  = '0;
          next_err_s    = 1'b1;
        end else begin
          next_rvalid_s = resp_valid;
        end
      end
      SAMPLE: begin
        next_rvalid_s = 1'b1;
        // Writes 3 and 4 leave the bool outputs stale, so no hit is reported for them.
        if ((op_r == 4'd3) || (op_r == 4'd4)) begin
          next_hit_s    = 1'b0;
          next_cell_s   = '0;
          next_count_s  = '0;
          next_rvalue_s = cell_result[DW-1:0];
          next_rctx_s   = cell_context[DW-1:0];
          next_err_s    = 1'b0;
        end else begin
          next_hit_s    = any_bool_s;
          next_cell_s   = low_s;
          next_count_s  = cnt_s;
          next_rvalue_s = res_low_s;
          next_rctx_s   = ctx_low_s;
          next_err_s    = multi_err_s;
        end
      end
      SAMPLE_SCAN: begin
        if (!any_bool_s) begin
          next_rvalid_s = 1'b1;
          next_hit_s    = 1'b0;
          next_cell_s   = '0;
          next_rvalue_s = '0;
          next_rctx_s   = '0;
          next_count_s  = '0;
          next_err_s    = 1'b1;
        end else begin
          next_rvalid_s = resp_valid;
        end
      end
      SAMPLE_WR: begin
        next_rvalid_s = 1'b1;
        next_hit_s    = bool_free_s;
        next_cell_s   = free_r;
        next_rvalue_s = res_free_s;
        next_rctx_s   = ctx_free_s;
        next_count_s  = cnt_s;
        next_err_s    = !bool_free_s;
      end
      RESP: begin
        if (resp_ready) begin
          next_rvalid_s = 1'b0;
        end else begin
          next_rvalid_s = 1'b1;
        end
      end
      default: next_rvalid_s = resp_valid;
    endcase
  end

endmodule

// File: tb/tb_esfa_cell_sequencer.sv
// Directed bench for esfa_cell_sequencer: a cell-array stand-in answers the bus, a transaction model predicts every cycle.
module tb_esfa_cell_sequencer;

`ifdef ESFA_SEQ_MULTIHIT_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif

  localparam int K_RAW = 0;
  localparam int K_INS = 1;
  localparam int K_ILL = 2;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, cmd_is_meta;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_index, cmd_value, cmd_metadata;
  logic [7:0]  cell_selector, cell_index, cell_value, cell_metadata;
  logic        cell_is_meta;
  logic [7:0]  cell_bool = 8'h00;
  logic [63:0] cell_result, cell_context;
  logic        resp_valid, resp_ready, resp_hit, resp_err;
  logic [2:0]  resp_cell;
  logic [7:0]  resp_value, resp_context;
  logic [3:0]  resp_count;

  always #5 clk = ~clk;

  esfa_cell_sequencer #(.N_CELLS(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_index(cmd_index), .cmd_value(cmd_value), .cmd_metadata(cmd_metadata), .cmd_is_meta(cmd_is_meta),
    .cell_selector(cell_selector), .cell_index(cell_index), .cell_value(cell_value),
    .cell_metadata(cell_metadata), .cell_is_meta(cell_is_meta),
    .cell_bool(cell_bool), .cell_result(cell_result), .cell_context(cell_context),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_cell(resp_cell),
    .resp_value(resp_value), .resp_context(resp_context), .resp_count(resp_count), .resp_err(resp_err)
  );

  // Cell array stand-in: cell i holds result A0+i and context C0+i; bool outputs are registered.
  logic [7:0] stub_lookup, stub_free;
  logic       stub_take;
  initial begin
    for (int i = 0; i < 8; i++) begin
      cell_result[i*8 +: 8]  = 8'hA0 + 8'(i);
      cell_context[i*8 +: 8] = 8'hC0 + 8'(i);
    end
  end
  always @(posedge clk) begin
    case (cell_selector)
      8'd5:       cell_bool <= stub_free;
      8'd3, 8'd4: cell_bool <= cell_bool;
      8'd0:       cell_bool <= cell_is_meta ? (stub_take ? (8'd1 << cell_metadata[2:0]) : 8'd0) : stub_lookup;
      default:    cell_bool <= stub_lookup;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: k counts clock edges since acceptance (0 = idle).
  int         k = 0;
  int         kind = K_RAW;
  int         m_lat = 0;
  bit         chk_en = 1'b0;
  logic [3:0] m_op;
  logic [7:0] m_idx, m_val, m_meta;
  logic       m_ism, m_full;
  logic [2:0] m_f;
  logic       e_hit, e_err;
  logic [2:0] e_cell;
  logic [3:0] e_count;
  logic [7:0] e_value, e_ctx;

  function automatic int first_one(input logic [7:0] m);
    int i = 0;
    while (i < 8 && !m[i]) i++;
    return (i == 8) ? 0 : i;
  endfunction

  // Per-cycle compare of the bus, handshake and response against the model.
  logic [7:0] es, ei, ev, em;
  logic       eim, evalid;
  always @(negedge clk) begin
    if (chk_en) begin
      es = 8'd5; ei = 8'd0; ev = 8'd0; em = 8'd0; eim = 1'b0;
      if (k == 1 && kind == K_RAW) begin
        es = {4'd0, m_op}; ei = m_idx; ev = m_val; em = m_meta; eim = m_ism;
      end else if (k == 3 && kind == K_INS && !m_full) begin
        es = 8'd0; ei = m_idx; ev = m_val; em = {5'd0, m_f}; eim = 1'b1;
      end
      evalid = (k != 0) && (k >= m_lat);
      check("cell_selector", cell_selector, es);
      check("cell_index", cell_index, ei);
      check("cell_value", cell_value, ev);
      check("cell_metadata", cell_metadata, em);
      check("cell_is_meta", cell_is_meta, eim);
      check("cmd_ready", cmd_ready, k == 0);
      check("resp_valid", resp_valid, evalid);
      if (evalid) begin
        check("resp_hit", resp_hit, e_hit);
        check("resp_cell", resp_cell, e_cell);
        check("resp_count", resp_count, e_count);
        check("resp_value", resp_value, e_value);
        check("resp_context", resp_context, e_ctx);
        check("resp_err", resp_err, e_err);
      end
    end
  end

  // Entered #1 after a posedge; builds the expectation, issues the command and completes the handshake.
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] idx, input logic [7:0] val,
                         input logic [7:0] meta, input logic ism, input logic [7:0] lookup,
                         input logic [7:0] free, input logic take, input int bp, input int rst_at);
    logic [7:0] mask, after;
    stub_lookup = lookup; stub_free = free; stub_take = take;
    m_op = op; m_idx = idx; m_val = val; m_meta = meta; m_ism = ism; m_full = 1'b0; m_f = 3'd0;
    if (op > 4'd8) begin
      kind = K_ILL; m_lat = 1;
      e_hit = 1'b0; e_cell = 3'd0; e_count = 4'd0; e_value = 8'd0; e_ctx = 8'd0; e_err = 1'b1;
    end else if (op == 4'd8) begin
      kind = K_INS; m_full = (free == 8'd0); m_f = 3'(first_one(free));
      if (m_full) begin
        m_lat = 3;
        e_hit = 1'b0; e_cell = 3'd0; e_count = 4'd0; e_value = 8'd0; e_ctx = 8'd0; e_err = 1'b1;
      end else begin
        m_lat = 5;
        after = take ? (8'd1 << m_f) : 8'd0;
        e_hit = take; e_cell = m_f; e_count = 4'($countones(after));
        e_value = 8'hA0 + {5'd0, m_f}; e_ctx = 8'hC0 + {5'd0, m_f}; e_err = !take;
      end
    end else begin
      kind = K_RAW; m_lat = 3;
      mask = (op == 4'd5) ? free : lookup;
      if (op == 4'd3 || op == 4'd4) begin
        e_hit = 1'b0; e_cell = 3'd0; e_count = 4'd0; e_err = 1'b0;
      end else begin
        e_hit = |mask; e_cell = 3'(first_one(mask)); e_count = 4'($countones(mask));
        e_err = MULTI && (op == 4'd1 || op == 4'd2 || op == 4'd6 || op == 4'd7) && (e_count > 4'd1);
      end
      e_value = 8'hA0 + {5'd0, e_cell}; e_ctx = 8'hC0 + {5'd0, e_cell};
    end

    cmd_valid = 1'b1; cmd_op = op; cmd_index = idx; cmd_value = val; cmd_metadata = meta; cmd_is_meta = ism;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 4'd0; cmd_index = 8'd0; cmd_value = 8'd0; cmd_metadata = 8'd0; cmd_is_meta = 1'b0;
    k = 1;
    while (k < m_lat + bp) begin
      if (k == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        k = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      k++;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    k = 0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_index = 8'd0; cmd_value = 8'd0;
    cmd_metadata = 8'd0; cmd_is_meta = 1'b0; resp_ready = 1'b0;
    stub_lookup = 8'd0; stub_free = 8'hFF; stub_take = 1'b1;
    m_op = 4'd0; m_idx = 8'd0; m_val = 8'd0; m_meta = 8'd0; m_ism = 1'b0; m_full = 1'b0; m_f = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_selector", cell_selector, 8'd5);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_resp_valid", resp_valid, 1'b0);
    check("reset_resp_err", resp_err, 1'b0);
    chk_en = 1'b1;

    // Raw lookup hitting cells 2 and 5.
    run_cmd(4'd1, 8'd3, 8'd0, 8'd2, 1'b1, 8'h24, 8'hFF, 1'b1, 0, -1);
    check("pin_lookup_cell", e_cell, 3'd2);
    check("pin_lookup_count", e_count, 4'd2);
    check("pin_lookup_value", e_value, 8'hA2);
    check("pin_lookup_err", e_err, MULTI);

    // INSERT with cells 0-2 used: free cell 3 takes the write.
    run_cmd(4'd8, 8'd7, 8'h44, 8'd0, 1'b0, 8'h00, 8'hF8, 1'b1, 0, -1);
    check("pin_insert_f", m_f, 3'd3);
    check("pin_insert_hit", e_hit, 1'b1);
    check("pin_insert_err", e_err, 1'b0);
    check("pin_insert_lat", m_lat, 5);

    // INSERT into a full array.
    run_cmd(4'd8, 8'd1, 8'h55, 8'd0, 1'b0, 8'h00, 8'h00, 1'b1, 0, -1);
    check("pin_full_err", e_err, 1'b1);
    check("pin_full_hit", e_hit, 1'b0);

    // INSERT where the chosen cell refuses the update.
    run_cmd(4'd8, 8'd2, 8'h66, 8'd0, 1'b0, 8'h00, 8'hF8, 1'b0, 0, -1);
    check("pin_refused_err", e_err, 1'b1);

    // Backpressure on a single-hit lookup.
    run_cmd(4'd6, 8'd9, 8'd1, 8'd4, 1'b0, 8'h80, 8'hFF, 1'b1, 4, -1);
    check("pin_bp_cell", e_cell, 3'd7);

    // Op 3 write pulse, then illegal op 12.
    run_cmd(4'd3, 8'd5, 8'h77, 8'd6, 1'b1, 8'h00, 8'hFF, 1'b1, 0, -1);
    check("pin_op3_hit", e_hit, 1'b0);
    run_cmd(4'd12, 8'd1, 8'd2, 8'd3, 1'b1, 8'h00, 8'hFF, 1'b1, 0, -1);
    check("pin_illegal_lat", m_lat, 1);

    // All cells hit, markAvailable resolve, and no hit.
    run_cmd(4'd7, 8'd0, 8'd0, 8'd0, 1'b0, 8'hFF, 8'hFF, 1'b1, 0, -1);
    check("pin_allhit_count", e_count, 4'd8);
    run_cmd(4'd5, 8'd0, 8'd0, 8'd0, 1'b0, 8'h00, 8'h30, 1'b1, 1, -1);
    check("pin_mark_cell", e_cell, 3'd4);
    run_cmd(4'd2, 8'd1, 8'd1, 8'd1, 1'b0, 8'h00, 8'hFF, 1'b1, 0, -1);
    check("pin_nohit_value", e_value, 8'hA0);

    // Reset while the INSERT write is on the bus.
    run_cmd(4'd8, 8'd7, 8'h44, 8'd0, 1'b0, 8'h00, 8'hF8, 1'b1, 0, 3);
    repeat (3) begin @(posedge clk); #1; end
    check("post_reset_hit", resp_hit, 1'b0);
    check("post_reset_cell", resp_cell, 3'd0);
    check("post_reset_count", resp_count, 4'd0);
    check("post_reset_value", resp_value, 8'd0);
    check("post_reset_context", resp_context, 8'd0);

    run_cmd(4'd1, 8'd2, 8'd0, 8'd1, 1'b0, 8'h02, 8'hFF, 1'b1, 0, -1);
    check("pin_after_reset_cell", e_cell, 3'd1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
